uart_xmt_scheduler: RTL and testbench
=====================================

# uart_xmt_scheduler

Shares one `uart_xmt` transmitter among `NREQ` byte sources with round-robin arbitration. For each granted byte it sequences the transmitter's `load_xmtdata_reg` → `byte_ready` → `t_byte` control pulses, then holds off for the full frame before granting again. The transmitter has no done flag, so the block times the frame itself in `enablex` ticks. It sits between the requesting blocks and `uart_xmt`, and runs on the same `clk`/`enablex`.

## Interface
- `wordsize`, 8, data bits per frame; must equal the transmitter's `wordsize`.
- `NREQ`, 4, number of requesters; must be ≥2.
- `STOP_GUARD`, 1, extra idle `enablex` ticks appended after each frame.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enablex`  input  1  baud tick; the same signal that drives the transmitter.
- `req_valid`  input  NREQ  bit i high = requester i has a byte pending.
- `req_data`  input  NREQ*wordsize  requester i byte at `[i*wordsize +: wordsize]`.
- `req_ready`  output  NREQ  one-cycle, one-hot accept pulse; the byte is taken on this cycle.
- `data_out`  output  wordsize  drives transmitter `data_in`.
- `load_xmtdata_reg`, `byte_ready`, `t_byte`  output  1 each  transmitter control.
- `busy`  output  1  high in every state except IDLE.
- `grant_id`  output  $clog2(NREQ)  index of the requester being served; holds its last value in IDLE.

## Operation
- FSM states: IDLE, LOAD, READY, START, WAIT.
- **IDLE:** arbitration runs on every `clk`, independent of `enablex`.
  - If any `req_valid` is high, grant the first set bit searching upward from `last_grant+1`, wrapping modulo NREQ.
  - Pulse `req_ready[g]`, capture `req_data[g]` into the hold register, set `grant_id = last_grant = g`, go to LOAD.
- **LOAD:** `load_xmtdata_reg = 1`. Advance to READY on a cycle with `enablex = 1`.
- **READY:** `byte_ready = 1`. Advance to START on a cycle with `enablex = 1`.
- **START:** `t_byte = 1`. On a cycle with `enablex = 1`, clear `tick_cnt` and go to WAIT.
- **WAIT:** `tick_cnt` increments on each `enablex`. When `tick_cnt == WAIT_TICKS-1` and `enablex = 1`, go to IDLE.
  - `WAIT_TICKS = wordsize + 2 + STOP_GUARD`: start bit, wordsize shifts, stop/clear tick, plus guard.
  - `tick_cnt` width is `$clog2(WAIT_TICKS+1)`.
- `data_out` is the hold register at all times and changes only on a grant.
- Control outputs are decoded from state (Moore).
  - Each control is high for at least one `enablex`-qualified edge, so the transmitter samples each exactly once.
  - Each control stays high while `enablex` is low.
- **Requester rules:**
  - A requester keeps `req_valid` and `req_data` stable until its `req_ready`.
  - Dropping `req_valid` before being granted withdraws the request; no grant is issued for it.
- **Reset:**
  - State → IDLE; `tick_cnt`, hold register, `grant_id` → 0; `last_grant` → NREQ-1, so requester 0 has first priority.
  - All outputs are 0 in the reset cycle and the cycle after.
  - Reset mid-frame aborts immediately with no further control pulses. The transmitter shares the reset and restarts cleanly.

## Timing
- Grant latency: one `clk` from `req_valid` high in IDLE to `req_ready`. `req_ready` is registered and high in the first cycle of LOAD.
- With `enablex` held high, one frame occupies 1 (IDLE) + 3 (LOAD/READY/START) + WAIT_TICKS clocks. For defaults that is 15 clocks from grant to the next possible grant.
- Back-to-back requests from several sources are granted in strict rotation. No requester waits more than NREQ-1 frames.
- `enablex` low freezes LOAD/READY/START/WAIT. IDLE still grants.

## Structure
- Shared package `uart_pkg`:
  - state enum `xmt_sched_state_t`;
  - `wait_ticks(wordsize, guard)` constant function;
  - default `wordsize`.
- Sub-module `rr_arbiter #(N)`:
  - inputs `req` and `last`, output one-hot `gnt` plus `gnt_idx`;
  - combinational;
  - reused by other shared-resource schedulers.
- Top level: FSM, hold register, `tick_cnt`, `last_grant`.

## Test plan
- **Single byte:** req0 `8'hA7`, `enablex` tied high.
  - `req_ready = 4'b0001` one cycle later.
  - `load_xmtdata_reg`, `byte_ready`, `t_byte` each high for exactly one clock, in order.
  - `serial_out` captured as 0, LSB-first `A7`, 1.
  - `busy` falls after 11 WAIT ticks.
- **Round-robin:** all four `req_valid` held high with distinct bytes.
  - Grants go 0,1,2,3,0.
  - `data_out` matches each granted byte.
  - Consecutive grants are exactly 15 clocks apart.
- **Priority rotation:** req2 only, then req1 and req3 together after the first frame → grant 3 before 1.
- **Slow baud:** `enablex` high 1 cycle in 16.
  - Each control pulse spans 16 clocks.
  - The WAIT phase spans 11×16 clocks.
  - The transmitter shifts out exactly one frame.
- **Reset mid-WAIT:** assert `reset` during the 5th WAIT tick.
  - Next cycle: `busy = 0` and all control outputs 0.
  - After release with req0 high, requester 0 is granted first.
- **Withdraw:** req1 valid during req0's frame, then dropped before the frame ends → no grant to 1 and the block stays IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, frame timing helper and
// the default word size.
package uart_pkg;

   localparam int unsigned WORDSIZE_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      READY,
      START,
      WAIT
   } xmt_sched_state_t;

   // enablex ticks a frame occupies: start bit, data shifts, stop/clear tick, guard
   function automatic int unsigned wait_ticks(input int unsigned wordsize,
                                              input int unsigned guard);
      return wordsize + 2 + guard;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from last+1, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int unsigned IW = $clog2(N);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = IW'((32'(last) + k) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/uart_xmt_scheduler.sv
// Round-robin sharing of one uart_xmt among NREQ byte sources; sequences the
// transmitter control pulses and times each frame in enablex ticks.
module uart_xmt_scheduler
   import uart_pkg::*;
#(
   parameter int unsigned wordsize   = WORDSIZE_DEFAULT,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned STOP_GUARD = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enablex,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*wordsize-1:0] req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [wordsize-1:0]      data_out,
   output logic                     load_xmtdata_reg,
   output logic                     byte_ready,
   output logic                     t_byte,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   localparam int unsigned WAIT_TICKS = wait_ticks(wordsize, STOP_GUARD);
   localparam int unsigned TW         = $clog2(WAIT_TICKS + 1);
   localparam int unsigned GW         = $clog2(NREQ);
   localparam logic [TW-1:0] TICK_LAST = TW'(WAIT_TICKS - 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

   xmt_sched_state_t    state_q, state_d;
   logic [TW-1:0]       tick_q;
   logic [wordsize-1:0] hold_q;
   logic [GW-1:0]       grant_id_q;
   logic [GW-1:0]       last_q;
   logic [NREQ-1:0]     ready_q;
   logic                post_reset_q;
   logic                grant_now;
   logic [NREQ-1:0]     arb_gnt;
   logic [GW-1:0]       arb_idx;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (req_valid),
      .last    (last_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // Granting is held off for one cycle after reset so all outputs stay low
   // through the reset cycle and the cycle after it.
   always_comb begin
      state_d          = state_q;
      grant_now        = 1'b0;
      load_xmtdata_reg = 1'b0;
      byte_ready       = 1'b0;
      t_byte           = 1'b0;
      busy             = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (|req_valid && !post_reset_q) begin
               grant_now = 1'b1;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            load_xmtdata_reg = 1'b1;
            if (enablex) state_d = READY;
         end
         READY: begin
            byte_ready = 1'b1;
            if (enablex) state_d = START;
         end
         START: begin
            t_byte = 1'b1;
            if (enablex) state_d = WAIT;
         end
         WAIT: begin
            if (enablex && tick_q == TICK_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         hold_q       <= '0;
         grant_id_q   <= '0;
         last_q       <= LAST_INIT;
         ready_q      <= '0;
         post_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         post_reset_q <= 1'b0;
         ready_q      <= grant_now ? arb_gnt : '0;
         if (grant_now) begin
            hold_q     <= req_data[arb_idx*wordsize +: wordsize];
            grant_id_q <= arb_idx;
            last_q     <= arb_idx;
         end
         if (state_q == START && enablex) begin
            tick_q <= '0;
         end else if (state_q == WAIT && enablex && tick_q != TICK_LAST) begin
            tick_q <= tick_q + TW'(1);
         end
      end
   end

   assign req_ready = ready_q;
   assign data_out  = hold_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_xmt_scheduler.sv
// Self-checking bench for uart_xmt_scheduler with a scoreboard of expected
// grants and a small behavioural transmitter that reassembles each frame.
module tb_uart_xmt_scheduler;

   localparam int FRAME_CLKS = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enablex = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  data_out;
   logic        load_xmtdata_reg, byte_ready, t_byte, busy;
   logic [1:0]  grant_id;

   uart_xmt_scheduler #(.wordsize(8), .NREQ(4), .STOP_GUARD(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .enablex          (enablex),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .data_out         (data_out),
      .load_xmtdata_reg (load_xmtdata_reg),
      .byte_ready       (byte_ready),
      .t_byte           (t_byte),
      .busy             (busy),
      .grant_id         (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct { int id; logic [7:0] data; } exp_t;
   typedef struct { logic [3:0] mask; logic [31:0] data; int exp_id; logic [7:0] exp_byte; } vec_t;

   exp_t       exp_q[$];
   logic [9:0] frame_q[$];
   vec_t       vecs[8];

   int n_checks = 0, n_fail = 0, cyc = 0;
   int grants_seen = 0, last_grant_cyc = -1, frames_seen = 0;
   int cnt_load = 0, cnt_ready = 0, cnt_start = 0, cnt_wait = 0;
   int en_div = 1, en_cnt = 0;
   bit gap_check = 1'b0;
   logic [3:0] last_ready = '0;

   bit         tx_active = 1'b0;
   int         tx_cnt = 0;
   logic [9:0] tx_sh = '1, rx_bits = '0;
   logic [7:0] tx_dreg = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmitter model: sees the values present for the coming clock edge.
   task automatic tx_model();
      if (reset) begin
         tx_active = 1'b0;
         tx_cnt    = 0;
         frame_q.delete();
      end else if (enablex) begin
         if (tx_active) begin
            rx_bits = {tx_sh[0], rx_bits[9:1]};
            tx_sh   = {1'b1, tx_sh[9:1]};
            tx_cnt++;
            if (tx_cnt == 10) begin
               tx_active = 1'b0;
               frames_seen++;
               if (frame_q.size() == 0) check("frame_unexpected", 32'(rx_bits), 32'h0);
               else check("frame", 32'(rx_bits), 32'(frame_q.pop_front()));
            end
         end
         if (load_xmtdata_reg) tx_dreg = data_out;
         if (byte_ready) tx_sh = {1'b1, tx_dreg, 1'b0};
         if (t_byte) begin
            tx_active = 1'b1;
            tx_cnt    = 0;
         end
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (load_xmtdata_reg) cnt_load++;
      if (byte_ready) cnt_ready++;
      if (t_byte) cnt_start++;
      if (busy && !load_xmtdata_reg && !byte_ready && !t_byte) cnt_wait++;
      if (req_ready != '0) begin
         grants_seen++;
         last_ready = req_ready;
         if (exp_q.size() == 0) begin
            check("unexpected_grant", 32'(req_ready), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("grant_onehot", 32'(req_ready), 32'(1) << e.id);
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("data_out", 32'(data_out), 32'(e.data));
            frame_q.push_back({1'b1, e.data, 1'b0});
         end
         if (gap_check && last_grant_cyc >= 0)
            check("grant_gap", 32'(cyc - last_grant_cyc), 32'(FRAME_CLKS));
         last_grant_cyc = cyc;
      end
   endtask

   task automatic step();
      tx_model();
      @(posedge clk);
      #1;
      cyc++;
      if (en_div <= 1) enablex = 1'b1;
      else begin
         en_cnt  = (en_cnt + 1) % en_div;
         enablex = (en_cnt == 0);
      end
      monitor();
   endtask

   task automatic push_exp(input int id, input logic [7:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input int bound);
      int g0 = grants_seen;
      for (int i = 0; i < bound && grants_seen == g0; i++) step();
      check("grant_timeout", 32'(grants_seen != g0), 32'h1);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && busy; i++) step();
      check("idle_timeout", 32'(busy), 32'h0);
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      req_valid = '0;
      gap_check = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   function automatic logic [31:0] outs();
      return 32'({req_ready, data_out, grant_id, load_xmtdata_reg, byte_ready, t_byte, busy});
   endfunction

   initial begin
      logic [3:0] masks[8];
      int         ids[8];
      logic [7:0] seq_exp;
      int         g0, f0, l0, r0, s0, w0, dl;

      masks = '{4'b0001, 4'b1111, 4'b1100, 4'b1101, 4'b0111, 4'b1000, 4'b0110, 4'b0011};
      ids   = '{0, 1, 2, 3, 0, 3, 1, 0};
      for (int i = 0; i < 8; i++) begin
         vecs[i].mask     = masks[i];
         vecs[i].exp_id   = ids[i];
         vecs[i].data     = {8'(64 + i + 1), 8'(48 + i + 1), 8'(32 + i + 1), 8'(16 + i + 1)};
         vecs[i].exp_byte = 8'((ids[i] + 1) * 16 + i + 1);
      end

      // reset state: outputs low in the reset cycle and the one after release
      reset = 1'b1;
      step();
      check("reset_outs", outs(), 32'h0);
      step();
      reset = 1'b0;
      step();
      check("post_reset_outs", outs(), 32'h0);

      // single byte, enablex tied high: exact per-cycle control sequence
      req_data  = 32'h0000_00A7;
      req_valid = 4'b0001;
      push_exp(0, 8'hA7);
      f0 = frames_seen;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k == 1) req_valid = '0;
         case (k)
            1:       seq_exp = 8'b0001_1001;
            2:       seq_exp = 8'b0000_0101;
            3:       seq_exp = 8'b0000_0011;
            15:      seq_exp = 8'b0000_0000;
            default: seq_exp = 8'b0000_0001;
         endcase
         check($sformatf("single_seq_%0d", k),
               32'({req_ready, load_xmtdata_reg, byte_ready, t_byte, busy}), 32'(seq_exp));
      end
      check("single_frames", 32'(frames_seen - f0), 32'h1);

      // round-robin with all four requesters held high
      apply_reset();
      req_data  = 32'h4433_2211;
      req_valid = 4'b1111;
      push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
      push_exp(3, 8'h44); push_exp(0, 8'h11);
      gap_check      = 1'b1;
      last_grant_cyc = -1;
      g0 = grants_seen;
      for (int i = 0; i < 100 && grants_seen < g0 + 5; i++) step();
      req_valid = '0;
      gap_check = 1'b0;
      check("rr_grant_count", 32'(grants_seen - g0), 32'h5);
      wait_idle(40);

      // priority rotation: after serving 2, requester 3 precedes 1
      apply_reset();
      req_data  = {8'h7E, 8'h5C, 8'h6D, 8'h00};
      req_valid = 4'b0100;
      push_exp(2, 8'h5C);
      wait_grant(5);
      req_valid = '0;
      repeat (3) step();
      req_valid = 4'b1010;
      push_exp(3, 8'h7E);
      push_exp(1, 8'h6D);
      wait_grant(30);
      req_valid = req_valid & ~last_ready;
      wait_grant(30);
      req_valid = '0;
      wait_idle(40);

      // table of arbitration vectors applied from reset
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         req_data  = vecs[i].data;
         req_valid = vecs[i].mask;
         push_exp(vecs[i].exp_id, vecs[i].exp_byte);
         wait_grant(5);
         req_valid = '0;
         wait_idle(40);
      end

      // slow baud: enablex high one cycle in sixteen
      en_div = 16;
      apply_reset();
      l0 = cnt_load; r0 = cnt_ready; s0 = cnt_start; w0 = cnt_wait; f0 = frames_seen;
      req_data  = 32'h0000_003C;
      req_valid = 4'b0001;
      push_exp(0, 8'h3C);
      wait_grant(5);
      req_valid = '0;
      wait_idle(400);
      dl = cnt_load - l0;
      check("slow_load_len", 32'(dl >= 1 && dl <= 16), 32'h1);
      check("slow_ready_len", 32'(cnt_ready - r0), 32'd16);
      check("slow_start_len", 32'(cnt_start - s0), 32'd16);
      check("slow_wait_len", 32'(cnt_wait - w0), 32'd176);
      check("slow_frames", 32'(frames_seen - f0), 32'h1);
      en_div = 1;

      // reset during the 5th WAIT tick aborts; requester 0 first afterwards
      apply_reset();
      req_data  = 32'h0000_B1A0;
      req_valid = 4'b0001;
      push_exp(0, 8'hA0);
      wait_grant(5);
      req_valid = '0;
      repeat (7) step();
      check("mid_wait_busy", 32'(busy), 32'h1);
      reset     = 1'b1;
      req_valid = 4'b0011;
      step();
      check("abort_outs", outs(), 32'h0);
      reset = 1'b0;
      step();
      check("abort_release_outs", outs(), 32'h0);
      push_exp(0, 8'hA0);
      wait_grant(5);
      req_valid = '0;
      wait_idle(40);

      // withdrawn request is never granted
      apply_reset();
      req_data  = 32'h0000_6F5E;
      req_valid = 4'b0001;
      push_exp(0, 8'h5E);
      wait_grant(5);
      req_valid = '0;
      g0 = grants_seen;
      repeat (3) step();
      req_valid = 4'b0010;
      repeat (5) step();
      req_valid = '0;
      wait_idle(40);
      repeat (20) step();
      check("withdraw_grants", 32'(grants_seen - g0), 32'h0);
      check("withdraw_idle", 32'(busy), 32'h0);

      check("exp_grants_left", 32'(exp_q.size()), 32'h0);
      check("exp_frames_left", 32'(frame_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
